// File: rtl/inv_div_scheduler.sv
// inv_div_scheduler
// -----------------------------------------------------------------------------
// Drives the adjugate-divided-by-determinant stage of a 4x4 matrix inverse
// through one shared, pipelined divider. A pass works as follows:
//   1. On start, the adjugate elements and the determinant are latched.
//   2. Every element is sent as a dividend with the determinant as the divisor.
//   3. Quotients come back in request order and are written into out_mat.
//
// Optional feature (compile-time macro INV_SINGULAR_CHECK_EN):
//   When the latched determinant is +0 or -0 (all bits except the sign are
//   zero), the pass sends no requests, clears out_mat and raises singular.
//   When the macro is not defined, every pass divides and singular is tied low.
//
// Ports
//   clk            single clock, rising edge
//   rst_n          synchronous, active-low reset
//   start          one-cycle request to begin a pass (ignored while busy)
//   adj_in         N packed elements; element i is at [i*DW +: DW]
//   det_in         determinant (divisor)
//   div_req_valid  request to the divider
//   div_req_ready  divider can take a request
//   div_a, div_b   dividend and divisor for the request
//   div_rsp_valid  quotient valid, returned in request order
//   div_q          quotient
//   out_mat        inverse elements, packed the same way as adj_in
//   busy           high from an accepted start until done
//   done           one-cycle pulse when out_mat is complete
//   singular       zero-determinant flag for the last pass
// -----------------------------------------------------------------------------
module inv_div_scheduler #(
    parameter int DW = 32,
    parameter int N  = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [N*DW-1:0] adj_in,
    input  logic [DW-1:0]   det_in,
    output logic            div_req_valid,
    input  logic            div_req_ready,
    output logic [DW-1:0]   div_a,
    output logic [DW-1:0]   div_b,
    input  logic            div_rsp_valid,
    input  logic [DW-1:0]   div_q,
    output logic [N*DW-1:0] out_mat,
    output logic            busy,
    output logic            done,
    output logic            singular
);

    localparam int IW = $clog2(N);
    // One extra bit so a counter can reach N without wrapping back to 0.
    localparam int CW = IW + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

    state_t         state_reg;
    logic [DW-1:0]  adj_reg [N];
    logic [DW-1:0]  det_reg;
    logic [DW-1:0]  out_reg [N];
    logic [DW-1:0]  adj_w   [N];
    logic [CW-1:0]  issue_cnt_reg;
    logic [CW-1:0]  ret_cnt_reg;
    logic           req_valid_reg;
    logic           busy_reg;
    logic           done_reg;
    logic           skip_w;

    // Unpack the input bus and pack the result registers.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_pack
            assign adj_w[gi]                = adj_in[gi*DW +: DW];
            assign out_mat[gi*DW +: DW]     = out_reg[gi];
        end
    endgenerate

`ifdef INV_SINGULAR_CHECK_EN
    logic singular_reg;
    // The sign bit is ignored, so both +0 and -0 count as zero.
    assign skip_w   = (det_reg[DW-2:0] == '0);
    assign singular = singular_reg;
`else
    assign skip_w   = 1'b0;
    assign singular = 1'b0;
`endif

    // Both operands come from registers that only change on an accepted start.
    // This keeps them stable for as long as a request is stalled.
    assign div_req_valid = req_valid_reg;
    assign div_a         = adj_reg[issue_cnt_reg[IW-1:0]];
    assign div_b         = det_reg;
    assign busy          = busy_reg;
    assign done          = done_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            issue_cnt_reg <= '0;
            ret_cnt_reg   <= '0;
            req_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
`ifdef INV_SINGULAR_CHECK_EN
            singular_reg  <= 1'b0;
`endif
            for (int i = 0; i < N; i++) begin
                out_reg[i] <= '0;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < N; i++) begin
                            adj_reg[i] <= adj_w[i];
                        end
                        det_reg       <= det_in;
                        issue_cnt_reg <= '0;
                        ret_cnt_reg   <= '0;
                        busy_reg      <= 1'b1;
                        state_reg     <= ISSUE;
`ifdef INV_SINGULAR_CHECK_EN
                        singular_reg  <= 1'b0;
                        // For a zero determinant, no request is ever raised.
                        // ISSUE then skips straight to FIN.
                        req_valid_reg <= (det_in[DW-2:0] != '0);
`else
                        req_valid_reg <= 1'b1;
`endif
                    end
                end

                ISSUE, DRAIN: begin
                    if (state_reg == ISSUE && skip_w) begin
                        for (int i = 0; i < N; i++) begin
                            out_reg[i] <= '0;
                        end
`ifdef INV_SINGULAR_CHECK_EN
                        singular_reg <= 1'b1;
`endif
                        req_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        done_reg      <= 1'b1;
                        state_reg     <= FIN;
                    end else begin
                        // req_valid_reg is always low in DRAIN.
                        // This branch therefore only fires in ISSUE.
                        if (req_valid_reg && div_req_ready) begin
                            issue_cnt_reg <= issue_cnt_reg + 1'b1;
                            if (issue_cnt_reg == LAST) begin
                                req_valid_reg <= 1'b0;
                                state_reg     <= DRAIN;
                            end
                        end
                        // A response can be taken in the same cycle as a
                        // request transfer.
                        if (div_rsp_valid) begin
                            out_reg[ret_cnt_reg[IW-1:0]] <= div_q;
                            ret_cnt_reg <= ret_cnt_reg + 1'b1;
                            if (ret_cnt_reg == LAST) begin
                                req_valid_reg <= 1'b0;
                                busy_reg      <= 1'b0;
                                done_reg      <= 1'b1;
                                state_reg     <= FIN;
                            end
                        end
                    end
                end

                FIN: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/inv_div_scheduler.md
INV_DIV_SCHEDULER -- requirements
Module: inv_div_scheduler

Interface
REQ-001 SHALL have parameter DW, default 32, element width in bits.
REQ-002 SHALL have parameter N, default 16, number of matrix elements (4x4).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to begin an inverse-divide pass.
REQ-006 SHALL have port adj_in  input  N*DW  adjugate elements; element i at bits [i*DW+DW-1 : i*DW].
REQ-007 SHALL have port det_in  input  DW  determinant (divisor).
REQ-008 SHALL have port div_req_valid  output  1  divide request valid to the shared divider.
REQ-009 SHALL have port div_req_ready  input  1  divider accepts a request.
REQ-010 SHALL have port div_a  output  DW  dividend.
REQ-011 SHALL have port div_b  output  DW  divisor.
REQ-012 SHALL have port div_rsp_valid  input  1  quotient valid, returned in request order.
REQ-013 SHALL have port div_q  input  DW  quotient.
REQ-014 SHALL have port out_mat  output  N*DW  inverse elements, same packing as adj_in.
REQ-015 SHALL have port busy  output  1  high from accepted start until done.
REQ-016 SHALL have port done  output  1  one-cycle pulse when out_mat is complete.
REQ-017 SHALL have port singular  output  1  determinant-zero flag for the last pass.

Function
REQ-018 SHALL implement states IDLE, ISSUE, DRAIN, FIN.
REQ-019 IDLE: start=1 SHALL latch adj_in and det_in into internal registers, clear issue/return counters, clear singular, and go to ISSUE; busy=1 the next cycle.
REQ-020 start while busy SHALL be ignored; latched operands SHALL not change during a pass.
REQ-021 ISSUE: div_req_valid=1, div_a=latched element[issue_cnt], div_b=latched det; a request SHALL transfer only when div_req_valid and div_req_ready are both 1.
REQ-022 div_a/div_b SHALL stay stable while div_req_valid=1 and div_req_ready=0.
REQ-023 Each transfer SHALL increment issue_cnt; after transfer of element N-1 the state SHALL go to DRAIN with div_req_valid=0.
REQ-024 In ISSUE and DRAIN, each div_rsp_valid=1 SHALL write div_q into out_mat element[ret_cnt] and increment ret_cnt; this includes a response in the same cycle as a request transfer.
REQ-025 Up to N requests MAY be outstanding; no ordering check beyond in-order return is required.
REQ-026 When response N-1 is written, the state SHALL go to FIN; FIN SHALL assert done for exactly one cycle, deassert busy, and return to IDLE.
REQ-027 Counters SHALL be log2(N)+1 bits wide and SHALL not wrap within a pass.
REQ-028 div_rsp_valid in IDLE or FIN SHALL be ignored.
REQ-029 out_mat SHALL hold its value from done until the next accepted start; it is undefined-but-stable while busy.
REQ-030 Minimum latency with an always-ready, 1-cycle divider SHALL be N+2 cycles from start to done.

Reset
REQ-031 rst_n=0 at a clock edge SHALL force IDLE, counters=0, busy=0, done=0, singular=0, div_req_valid=0, out_mat=0.
REQ-032 Reset mid-pass SHALL abort; responses to earlier requests that arrive after reset SHALL be ignored.

Configuration
REQ-033 Macro INV_SINGULAR_CHECK_EN SHALL control zero-determinant handling.
REQ-034 With INV_SINGULAR_CHECK_EN defined, when latched det[DW-2:0]==0 (+0 or -0): skip ISSUE/DRAIN, issue no requests, set out_mat=0, singular=1, go directly to FIN.
REQ-035 Without INV_SINGULAR_CHECK_EN, all passes SHALL divide normally and singular SHALL be tied 0.

Verification
REQ-036 Always-ready divider with 1-cycle latency, adj element i = i, det = 1.0 -> 16 requests in consecutive cycles, done at cycle N+2, out_mat element i = quotient i.
REQ-037 div_req_ready toggling 1,0,1,0 -> div_a/div_b stable while stalled, exactly 16 transfers, no duplicate or skipped index.
REQ-038 Divider latency 5 cycles, 5 outstanding -> responses written to indices 0..15 in order, done one cycle after the 16th response.
REQ-039 Macro defined, det_in=32'h8000_0000 -> zero requests, singular=1, out_mat=0, done pulses 2 cycles after start.
REQ-040 start reasserted at cycle 3 of a pass -> ignored, operands unchanged; rst_n=0 at cycle 6 -> IDLE next cycle, subsequent div_rsp_valid ignored, busy=0.
